// File: rtl/ika2151_dacrx.sv
// ika2151_dacrx: receiver end of the IKA2151 serial audio output.
// Samples SO on phi1 ticks, captures the 13-bit float word at SH1/SH2
// falling edges, checks the 32-tick frame cadence and, once locked,
// presents decoded CH1/CH2 pairs with a one-cycle valid strobe.
// Optional: define IKA2151_DACRX_FRAME_CHECK_EN to get o_FRAME_ERR
// pulses on framing violations seen while locked.
module ika2151_dacrx #(
  parameter int LOCK_FRAMES = 2
) (
  input  logic        i_EMUCLK,
  input  logic        i_RST,
  input  logic        i_phi1_NCEN_n,
  input  logic        i_SO,
  input  logic        i_SH1,
  input  logic        i_SH2,
  output logic [15:0] o_CH1,
  output logic [15:0] o_CH2,
  output logic        o_SAMPLE_VALID,
  output logic        o_LOCKED,
  output logic        o_FRAME_ERR
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Frame slots, compared against the counter value this tick advances to.
  localparam logic [4:0] SH1_SLOT = 5'd0;
  localparam logic [4:0] SH1_LATE = 5'd1;
  localparam logic [4:0] SH2_SLOT = 5'd16;
  localparam logic [4:0] SH2_LATE = 5'd17;

  localparam logic [2:0] LOCK_N = 3'(LOCK_FRAMES);

  logic        tick;
  // Upper 13 bits of the 16-bit serial shift register; the lowest three
  // bits fall off before they could ever be part of a captured word.
  logic [12:0] sr;
  logic        sh1_prev, sh2_prev;
  logic        sh1_fall, sh2_fall;
  logic [4:0]  cnt, cnt_inc;
  logic [1:0]  state, state_nx;
  logic [2:0]  good, good_nx;
  logic        sh2_ok, sh2_ok_nx;
  logic        viol, commit;
  logic [15:0] word_dec;
  logic [15:0] ch2_stage;

  // {exp[2:0], mant[9:0]} -> signed linear; mantissa MSB is offset-binary.
  function automatic logic [15:0] decode(input logic [12:0] w);
    logic [15:0] m;
    m = {{6{~w[9]}}, ~w[9], w[8:0]};
    if (w[12:10] == 3'd0) return 16'd0;
    return m << (w[12:10] - 3'd1);
  endfunction

  assign tick     = ~i_phi1_NCEN_n;
  assign sh1_fall = sh1_prev & ~i_SH1;
  assign sh2_fall = sh2_prev & ~i_SH2;
  assign cnt_inc  = cnt + 5'd1;
  assign word_dec = decode(sr);
  assign o_LOCKED = (state == ST_LOCKED);

  // Frame-sync decisions for the current tick (applied only when tick=1).
  always_comb begin
    state_nx  = state;
    good_nx   = good;
    sh2_ok_nx = sh2_ok;
    viol      = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_HUNT: begin
        sh2_ok_nx = 1'b0;
        // A simultaneous SH2 fall makes this edge unusable as a frame start.
        if (sh1_fall && !sh2_fall) begin
          state_nx = ST_TRACK;
          good_nx  = 3'd0;
        end
      end
      ST_TRACK, ST_LOCKED: begin
        // Early/late falls and falls that never arrived (slot passed).
        viol = (sh2_fall && (cnt_inc != SH2_SLOT))
            || (sh1_fall && ((cnt_inc != SH1_SLOT) || !sh2_ok))
            || (!sh2_ok && !sh2_fall && (cnt_inc == SH2_LATE))
            || (sh2_ok && !sh1_fall && (cnt_inc == SH1_LATE));
        if (viol) begin
          state_nx  = ST_HUNT;
          sh2_ok_nx = 1'b0;
        end else if (sh2_fall) begin
          sh2_ok_nx = 1'b1;
        end else if (sh1_fall) begin
          sh2_ok_nx = 1'b0;
          if (state == ST_LOCKED) begin
            commit = 1'b1;
          end else begin
            good_nx = good + 3'd1;
            if (good_nx == LOCK_N) state_nx = ST_LOCKED;
          end
        end
      end
      default: begin
        state_nx  = ST_HUNT;
        sh2_ok_nx = 1'b0;
      end
    endcase
  end

  // Serial bit capture and strobe history, advanced once per phi1 tick.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      sr       <= '0;
      sh1_prev <= 1'b0;
      sh2_prev <= 1'b0;
    end else if (tick) begin
      sr       <= {i_SO, sr[12:1]};
      sh1_prev <= i_SH1;
      sh2_prev <= i_SH2;
    end
  end

  // Position within the 32-tick frame, realigned at every SH1 fall.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST)      cnt <= 5'd0;
    else if (tick)  cnt <= sh1_fall ? 5'd0 : cnt_inc;
  end

  // Frame-sync state machine registers.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      state  <= ST_HUNT;
      good   <= 3'd0;
      sh2_ok <= 1'b0;
    end else if (tick) begin
      state  <= state_nx;
      good   <= good_nx;
      sh2_ok <= sh2_ok_nx;
    end
  end

  // Hold the decoded SH2 word until the SH1 fall that closes the frame.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST)                 ch2_stage <= 16'd0;
    else if (tick && sh2_fall) ch2_stage <= word_dec;
  end

  // Commit the CH1/CH2 pair on a good SH1 fall while locked.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      o_CH1          <= 16'd0;
      o_CH2          <= 16'd0;
      o_SAMPLE_VALID <= 1'b0;
    end else begin
      o_SAMPLE_VALID <= tick & commit;
      if (tick && commit) begin
        o_CH1 <= word_dec;
        o_CH2 <= ch2_stage;
      end
    end
  end

`ifdef IKA2151_DACRX_FRAME_CHECK_EN
  // One-cycle error pulse for any violation that breaks an existing lock.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) o_FRAME_ERR <= 1'b0;
    else       o_FRAME_ERR <= tick & viol & (state == ST_LOCKED);
  end
`else
  assign o_FRAME_ERR = 1'b0;
`endif

endmodule
